// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : opcode, register-select and write-back codes, controller states
// Revision 1.0
// ============================================================================
package cpu_pkg;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;

  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] RS_RN   = 2'b10;
  localparam logic [1:0] RS_RD   = 2'b01;
  localparam logic [1:0] RS_RM   = 2'b00;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_IMM  = 2'b10;

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_IMM  = 3'd1,
    S_LDA  = 3'd2,
    S_LDB  = 3'd3,
    S_EXEC = 3'd4,
    S_CMP  = 3'd5,
    S_WB   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// cpu_controller : Moore FSM sequencing register file / ALU / shifter datapath
// Revision 1.0
// ============================================================================
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [1:0]       ALU_op,
  output logic             waiting,
  output logic [1:0]       reg_sel,
  output logic [1:0]       wb_sel,
  output logic             w_en,
  output logic             en_A,
  output logic             en_B,
  output logic             en_C,
  output logic             en_status,
  output logic             sel_A,
  output logic             sel_B,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retired_d = retired_q;
    illegal_d = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (start) begin
          op_d = {opcode, ALU_op};
          case ({opcode, ALU_op})
            {OP_MOV, MOV_IMM}:                    state_d = S_IMM;
            {OP_MOV, MOV_REG}, {OP_ALU, ALU_MVN}: state_d = S_LDB;
            {OP_ALU, ALU_ADD}, {OP_ALU, ALU_AND},
            {OP_ALU, ALU_CMP}:                    state_d = S_LDA;
            default:                              illegal_d = 1'b1;
          endcase
        end
      end
      S_IMM, S_WB, S_CMP: begin
        state_d   = S_WAIT;
        retired_d = retired_q + CNT_W'(1);
      end
      S_LDA:   state_d = S_LDB;
      S_LDB:   state_d = (op_q == {OP_ALU, ALU_CMP}) ? S_CMP : S_EXEC;
      S_EXEC:  state_d = S_WB;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT;
      op_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes decode the state register only; the spare encoding drives nothing.
  always_comb begin
    waiting   = 1'b0;
    reg_sel   = RS_RM;
    wb_sel    = WB_ALU;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    case (state_q)
      S_WAIT: waiting = 1'b1;
      S_IMM: begin
        reg_sel = RS_RN;
        wb_sel  = WB_IMM;
        w_en    = 1'b1;
      end
      S_LDA: begin
        reg_sel = RS_RN;
        en_A    = 1'b1;
      end
      S_LDB: begin
        reg_sel = RS_RM;
        en_B    = 1'b1;
      end
      S_EXEC: begin
        en_C  = 1'b1;
        sel_A = (op_q == {OP_MOV, MOV_REG}) || (op_q == {OP_ALU, ALU_MVN});
      end
      S_CMP: en_status = 1'b1;
      S_WB: begin
        reg_sel = RS_RD;
        wb_sel  = WB_ALU;
        w_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
`default_nettype wire
